// File: rtl/aes_inv_core_pkg.sv
// aes_inv_core_pkg: AES-128 constants, FSM states, GF(2^8) helpers and S-box functions.
package aes_inv_core_pkg;
  localparam int NR = 10;
  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUNDS, DONE} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, b;
    r = 8'h01;
    b = a;
    for (int k = 0; k < 8; k++) begin
      r = (k != 0) ? gmul(r, b) : r;
      b = gmul(b, b);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < NR; k++) r = (k < int'(i)) ? xtime(r) : r;
    return (i == 4'd0 || int'(i) > NR) ? 32'h0 : {r, 24'h0};
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] x2, x4, x8, b;
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    for (int j = 0; j < 4; j++) begin
      b = a[31-8*j -: 8];
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[j] = x8 ^ b;
      mb[j] = x8 ^ x2 ^ b;
      md[j] = x8 ^ x4 ^ b;
      me[j] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
endpackage

// File: rtl/aes_inv_core_if.sv
// aes_inv_core_if: load/key/cyphertext in, done/plaintext out.
interface aes_inv_core_if;
  logic load, done;
  logic [127:0] key, cyphertext, plaintext;
  modport master(output load, key, cyphertext, input done, plaintext);
  modport slave(input load, key, cyphertext, output done, plaintext);
endinterface

// File: rtl/aes_inv_core_round.sv
// aes_inv_core_round: one combinational inverse round; InvMixColumns skipped on the last round.
module aes_inv_core_round
  import aes_inv_core_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic         last_i,
  output logic [127:0] state_o
);
  logic [127:0] ark, mix;
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r rotates right by r: output column c takes input column c-r.
      assign ark[127-8*(4*c+r) -: 8] = inv_sbox(state_i[127-8*(4*((c+4-r)%4)+r) -: 8]) ^ key_i[127-8*(4*c+r) -: 8];
    end
    assign mix[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end
  assign state_o = last_i ? ark : mix;
endmodule

// File: rtl/aes_inv_core.sv
// aes_inv_core: iterative AES-128 decryptor; expands the key forward, then unwinds it during the rounds.
module aes_inv_core
  import aes_inv_core_pkg::*;
(
  input logic          clk,
  input logic          reset,
  aes_inv_core_if.slave bus
);
  state_t state_q;
  logic [3:0] rnd_q;
  logic [127:0] kreg_q, sreg_q, pt_q, round_out;
  logic done_q;
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] n0, n1, n2;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ rc;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    return {n0, n1, n2, k[31:0] ^ n2};
  endfunction
  function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] p3;
    p3 = k[31:0] ^ k[63:32];
    return {k[127:96] ^ sub_rot(p3) ^ rc, k[95:64] ^ k[127:96], k[63:32] ^ k[95:64], p3};
  endfunction
  aes_inv_core_round u_round (
    .state_i(sreg_q),
    .key_i  (kreg_q),
    .last_i (rnd_q == 4'd0),
    .state_o(round_out)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      kreg_q  <= '0;
      sreg_q  <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
    end else if (bus.load) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      kreg_q  <= bus.key;
      sreg_q  <= bus.cyphertext;
      done_q  <= 1'b0;
    end else
      case (state_q)
        IDLE: begin
          state_q <= KEYEXP;
          rnd_q   <= 4'd1;
        end
        KEYEXP: begin
          kreg_q  <= next_key(kreg_q, rcon(rnd_q));
          rnd_q   <= rnd_q + 4'd1;
          state_q <= (rnd_q == 4'(NR)) ? INIT : KEYEXP;
        end
        INIT: begin
          sreg_q  <= sreg_q ^ kreg_q;
          kreg_q  <= prev_key(kreg_q, rcon(4'(NR)));
          rnd_q   <= 4'(NR - 1);
          state_q <= ROUNDS;
        end
        ROUNDS: begin
          sreg_q <= round_out;
          if (rnd_q != 4'd0) begin
            kreg_q <= prev_key(kreg_q, rcon(rnd_q));
            rnd_q  <= rnd_q - 4'd1;
          end else begin
            pt_q    <= round_out;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= DONE;
      endcase
  assign bus.done      = done_q;
  assign bus.plaintext = pt_q;
endmodule
